if_fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage that replaces the bare PC-plus-combinational-memory fetch.
- Drives a synchronous-read instruction memory with a fixed 1-cycle response and buffers returned instructions in a FB_DEPTH-entry FIFO.
- Presents {pc, instr} to decode through a valid/ready handshake.
- Supports backpressure from decode and branch/jump redirect, with flush of buffered and in-flight fetches.

---
 rtl/if_fetch_unit.sv | 96 +++++++++
 tb/tb_if_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch into a FB_DEPTH-entry buffer with redirect flush; optional IF_MISALIGN_CHECK_EN
module if_fetch_unit #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int FB_DEPTH = 4,
  parameter int IMEM_ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   imem_req_valid,
  output logic [IMEM_ADDR_W-1:0] imem_req_addr,
  input  logic [31:0]            imem_rsp_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [31:0]            out_instr,
  output logic                   misalign_fault
);
  localparam int PW = $clog2(FB_DEPTH);
  localparam int NW = PW + 1;
  localparam int CW = PW + 2;
  logic [XLEN-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] fb_pc_q [FB_DEPTH];
  logic [XLEN-1:0] fb_pc_d [FB_DEPTH];
  logic [31:0]     fb_ins_q [FB_DEPTH];
  logic [31:0]     fb_ins_d [FB_DEPTH];
  logic            halted, pop, push, issue;
`ifdef IF_MISALIGN_CHECK_EN
  logic fault_q, fault_d;
  // A misaligned redirect halts fetch until reset or an aligned redirect
  always_comb fault_d = redirect_valid ? (redirect_pc[1:0] != 2'b00) : fault_q;
  // Fault flag register
  always_ff @(posedge clk or posedge reset)
    if (reset) fault_q <= 1'b0;
    else fault_q <= fault_d;
  assign halted = fault_q;
  assign misalign_fault = fault_q;
`else
  assign halted = 1'b0;
  assign misalign_fault = 1'b0;
`endif
  // Handshake, credit-based issue and head presentation; nothing is requested while reset is held
  always_comb begin
    out_valid = cnt_q != '0;
    pop = out_valid & out_ready & !redirect_valid;
    push = inflight_q & !redirect_valid;
    issue = !reset & !redirect_valid & !halted &
            (CW'(cnt_q) + CW'(inflight_q) < CW'(FB_DEPTH) + CW'(out_valid & out_ready));
    imem_req_valid = issue;
    imem_req_addr = pc_q[IMEM_ADDR_W+1:2];
    out_pc = out_valid ? fb_pc_q[rd_q] : '0;
    out_instr = out_valid ? fb_ins_q[rd_q] : '0;
  end
  // Next state: redirect clears the buffer and drops the in-flight response
  always_comb begin
    pc_d = redirect_valid ? (redirect_pc & ~XLEN'(3)) : issue ? pc_q + XLEN'(4) : pc_q;
    inflight_d = issue;
    inflight_pc_d = issue ? pc_q : inflight_pc_q;
    rd_d = redirect_valid ? '0 : rd_q + PW'(pop);
    wr_d = redirect_valid ? '0 : wr_q + PW'(push);
    cnt_d = redirect_valid ? '0 : cnt_q + NW'(push) - NW'(pop);
    fb_pc_d = fb_pc_q;
    fb_ins_d = fb_ins_q;
    if (push) begin
      fb_pc_d[wr_q] = inflight_pc_q;
      fb_ins_d[wr_q] = imem_rsp_data;
    end
  end
  // Control state registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      inflight_q <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  // Buffer storage needs no reset; entries are only visible below cnt_q
  always_ff @(posedge clk) begin
    fb_pc_q <= fb_pc_d;
    fb_ins_q <= fb_ins_d;
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;
  typedef struct packed {logic [63:0] pc; logic [31:0] ins;} ent_t;
  logic        clk = 0, reset = 1, redirect_valid = 0, out_ready = 0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req_valid, out_valid, misalign_fault;
  logic [7:0]  imem_req_addr;
  logic [31:0] imem_rsp_data = '0, out_instr;
  logic [63:0] out_pc;
  logic        w_req, w_ov, w_fault;
  logic [1:0]  w_addr;
  logic [31:0] w_rsp = '0, w_ins;
  logic [63:0] w_pc;
  int          n_chk = 0, n_fail = 0, req_cnt = 0;
  ent_t        sb[$];
  ent_t        e;

  if_fetch_unit u_dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .misalign_fault(misalign_fault)
  );

  if_fetch_unit #(.IMEM_ADDR_W(2)) u_w (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(w_req), .imem_req_addr(w_addr), .imem_rsp_data(w_rsp),
    .out_valid(w_ov), .out_ready(out_ready), .out_pc(w_pc), .out_instr(w_ins),
    .misalign_fault(w_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] n);
    return 32'h13 + (n << 7);
  endfunction

  always @(posedge clk) begin
    imem_rsp_data <= word(32'(imem_req_addr));
    w_rsp <= word(32'(w_addr));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_load(input logic [63:0] a);
    ent_t x;
    logic [63:0] p;
    sb.delete();
    for (int i = 0; i < 128; i++) begin
      p = a + 64'(4 * i);
      x.pc = p;
      x.ins = word(32'(p[9:2]));
      sb.push_back(x);
    end
  endtask

  always begin
    @(negedge clk);
    #4;
    if (!reset) begin
      if (imem_req_valid) req_cnt++;
      if (out_valid && out_ready && !redirect_valid) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_pc", out_pc, e.pc);
          chk("sb_instr", 64'(out_instr), 64'(e.ins));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", imem_req_valid, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_ins", 64'(out_instr), 0);
    chk("rst_fault", misalign_fault, 0);
    @(negedge clk);
    reset = 0;
    sb_load(64'h0);
    req_cnt = 0;
    repeat (10) @(negedge clk);
    #1;
    chk("bp_reqs", 64'(req_cnt), 4);
    chk("bp_req_off", imem_req_valid, 0);
    chk("bp_ov", out_valid, 1);
    chk("bp_pc_hold", out_pc, 0);
    chk("bp_ins_hold", 64'(out_instr), 64'h13);
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      #1;
      chk("drain_pc", out_pc, 64'(4 * i));
      chk("drain_ov", out_valid, 1);
    end
    @(negedge clk);
    #2;
    reset = 1;
    #1;
    chk("arst_ov", out_valid, 0);
    chk("arst_req", imem_req_valid, 0);
    chk("arst_pc", out_pc, 0);
    @(negedge clk);
    reset = 0;
    sb_load(64'h0);
    #1;
    chk("lat_req", imem_req_valid, 1);
    chk("lat_addr0", 64'(imem_req_addr), 0);
    chk("wrap_addr0", 64'(w_addr), 0);
    chk("lat_ov0", out_valid, 0);
    @(negedge clk);
    #1;
    chk("lat_addr1", 64'(imem_req_addr), 1);
    chk("wrap_addr1", 64'(w_addr), 1);
    chk("lat_ov1", out_valid, 0);
    @(negedge clk);
    #1;
    chk("lat_addr2", 64'(imem_req_addr), 2);
    chk("wrap_addr2", 64'(w_addr), 2);
    chk("lat_ov2", out_valid, 1);
    chk("lat_pc", out_pc, 0);
    chk("lat_ins", 64'(out_instr), 64'h13);
    @(negedge clk);
    #1;
    chk("wrap_addr3", 64'(w_addr), 3);
    chk("tp_pc4", out_pc, 4);
    @(negedge clk);
    #1;
    chk("wrap_addr4", 64'(w_addr), 0);
    chk("tp_pc8", out_pc, 8);
    repeat (2) @(negedge clk);
    #1;
    chk("wrap_pc", w_pc, 16);
    chk("wrap_ins", 64'(w_ins), 64'h13);
    chk("tp_ins16", 64'(out_instr), 64'h213);
    @(negedge clk);
    out_ready = 0;
    repeat (2) @(negedge clk);
    redirect_valid = 1;
    redirect_pc = 64'h100;
    sb_load(64'h100);
    #1;
    chk("rd_req", imem_req_valid, 0);
    chk("rd_ov_before", out_valid, 1);
    @(negedge clk);
    redirect_valid = 0;
    out_ready = 1;
    #1;
    chk("rd_flush", out_valid, 0);
    chk("rd_req1", imem_req_valid, 1);
    chk("rd_addr", 64'(imem_req_addr), 64'h40);
    @(negedge clk);
    #1;
    chk("rd_ov2", out_valid, 0);
    @(negedge clk);
    #1;
    chk("rd_ov3", out_valid, 1);
    chk("rd_pc", out_pc, 64'h100);
    repeat (3) @(negedge clk);
    redirect_valid = 1;
    redirect_pc = 64'h20;
    sb_load(64'h20);
    #1;
    chk("b2b_ov", out_valid, 1);
    @(negedge clk);
    redirect_pc = 64'h80;
    sb_load(64'h80);
    #1;
    chk("b2b_flush", out_valid, 0);
    chk("b2b_req", imem_req_valid, 0);
    @(negedge clk);
    redirect_valid = 0;
    #1;
    chk("b2b_addr", 64'(imem_req_addr), 64'h20);
    chk("b2b_ov1", out_valid, 0);
    @(negedge clk);
    #1;
    chk("b2b_ov2", out_valid, 0);
    @(negedge clk);
    #1;
    chk("b2b_ov3", out_valid, 1);
    chk("b2b_pc", out_pc, 64'h80);
    repeat (2) @(negedge clk);
    redirect_valid = 1;
    redirect_pc = 64'h102;
`ifdef IF_MISALIGN_CHECK_EN
    sb.delete();
    @(negedge clk);
    redirect_valid = 0;
    #1;
    chk("mis_fault", misalign_fault, 1);
    chk("mis_req", imem_req_valid, 0);
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("mis_halt_req", imem_req_valid, 0);
      chk("mis_halt_ov", out_valid, 0);
      chk("mis_hold", misalign_fault, 1);
    end
    @(negedge clk);
    redirect_valid = 1;
    redirect_pc = 64'h200;
    sb_load(64'h200);
    @(negedge clk);
    redirect_valid = 0;
    #1;
    chk("mis_clear", misalign_fault, 0);
    chk("mis_resume", imem_req_valid, 1);
    chk("mis_addr", 64'(imem_req_addr), 64'h80);
    repeat (2) @(negedge clk);
    #1;
    chk("mis_pc", out_pc, 64'h200);
`else
    sb_load(64'h100);
    @(negedge clk);
    redirect_valid = 0;
    #1;
    chk("mis_fault", misalign_fault, 0);
    chk("mis_req", imem_req_valid, 1);
    chk("mis_addr", 64'(imem_req_addr), 64'h40);
    repeat (2) @(negedge clk);
    #1;
    chk("mis_pc", out_pc, 64'h100);
    chk("mis_fault2", misalign_fault, 0);
`endif
    repeat (5) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
